// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared BTB geometry, counter encodings and entry type
package branch_pkg;

    localparam int BTB_ENTRIES_DEF = 16;
    localparam int TAG_MAX_BITS    = 30;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Tag field sized for the smallest table; narrower tags are zero-extended.
    typedef struct packed {
        logic                    valid;
        logic [TAG_MAX_BITS-1:0] tag;
        logic [31:0]             target;
        logic [1:0]              ctr;
    } btb_entry_t;

    function automatic int index_bits(input int entries);
        return $clog2(entries);
    endfunction

    function automatic int tag_bits(input int entries);
        return 30 - index_bits(entries);
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - 2-bit saturating branch counter next-state logic
module sat_counter2
    import branch_pkg::*;
(
    input  logic [1:0] i_ctr,
    input  logic       i_taken,
    output logic [1:0] o_next_ctr
);

    always_comb begin
        o_next_ctr = i_ctr;
        case (i_ctr)
            CTR_SNT: o_next_ctr = i_taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: o_next_ctr = i_taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  o_next_ctr = i_taken ? CTR_ST  : CTR_WNT;
            default: o_next_ctr = i_taken ? CTR_ST  : CTR_WT;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters and mispredict redirect
module branch_predictor
    import branch_pkg::*;
#(
    parameter int BTB_ENTRIES = BTB_ENTRIES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    output logic        pred_valid,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc
);

    localparam int INDEX_BITS = index_bits(BTB_ENTRIES);
    localparam int TAG_BITS   = tag_bits(BTB_ENTRIES);

    btb_entry_t r_btb [BTB_ENTRIES];

    logic        r_pred_valid;
    logic        r_pred_taken;
    logic [31:0] r_pred_target;
    logic        r_mispredict;
    logic [31:0] r_redirect_pc;

    logic [INDEX_BITS-1:0]   w_f_idx;
    logic [TAG_MAX_BITS-1:0] w_f_tag;
    logic                    w_f_hit;
    logic [INDEX_BITS-1:0]   w_u_idx;
    logic [TAG_MAX_BITS-1:0] w_u_tag;
    logic                    w_u_hit;
    logic [1:0]              w_next_ctr;
    logic                    w_mispredict;

    assign w_f_idx = fetch_pc[INDEX_BITS+1:2];
    assign w_f_tag = TAG_MAX_BITS'(fetch_pc[31:32-TAG_BITS]);
    assign w_f_hit = r_btb[w_f_idx].valid && (r_btb[w_f_idx].tag == w_f_tag);

    assign w_u_idx = upd_pc[INDEX_BITS+1:2];
    assign w_u_tag = TAG_MAX_BITS'(upd_pc[31:32-TAG_BITS]);
    assign w_u_hit = r_btb[w_u_idx].valid && (r_btb[w_u_idx].tag == w_u_tag);

    assign w_mispredict = (upd_taken != upd_pred_taken) ||
                          (upd_taken && (upd_target != upd_pred_target));

    sat_counter2 u_sat_counter2 (
        .i_ctr      (r_btb[w_u_idx].ctr),
        .i_taken    (upd_taken),
        .o_next_ctr (w_next_ctr)
    );

    // Lookup reads the array before this edge's update lands, so same-index
    // fetch/update pairs see the old entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_btb[i].valid <= 1'b0;
            end
            r_pred_valid  <= 1'b0;
            r_pred_taken  <= 1'b0;
            r_pred_target <= 32'h0;
            r_mispredict  <= 1'b0;
            r_redirect_pc <= 32'h0;
        end else begin
            r_pred_valid <= fetch_valid;
            if (fetch_valid) begin
                r_pred_taken  <= w_f_hit && r_btb[w_f_idx].ctr[1];
                r_pred_target <= (w_f_hit && r_btb[w_f_idx].ctr[1]) ?
                                 r_btb[w_f_idx].target : fetch_pc + 32'd4;
            end

            r_mispredict <= upd_valid && w_mispredict;
            if (upd_valid && w_mispredict) begin
                r_redirect_pc <= upd_taken ? upd_target : upd_pc + 32'd4;
            end

            if (upd_valid) begin
                if (w_u_hit) begin
                    r_btb[w_u_idx].ctr <= w_next_ctr;
                    if (upd_taken) begin
                        r_btb[w_u_idx].target <= upd_target;
                    end
                end else if (upd_taken) begin
                    r_btb[w_u_idx].valid  <= 1'b1;
                    r_btb[w_u_idx].tag    <= w_u_tag;
                    r_btb[w_u_idx].target <= upd_target;
                    r_btb[w_u_idx].ctr    <= CTR_WT;
                end
            end
        end
    end

    assign pred_valid  = r_pred_valid;
    assign pred_taken  = r_pred_taken;
    assign pred_target = r_pred_target;
    assign mispredict  = r_mispredict;
    assign redirect_pc = r_redirect_pc;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    branch_predictor #(.BTB_ENTRIES(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_valid     (fetch_valid),
        .fetch_pc        (fetch_pc),
        .pred_valid      (pred_valid),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
        .redirect_pc     (redirect_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt);
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_taken       = tk;
        upd_target      = tgt;
        upd_pred_taken  = ptk;
        upd_pred_target = ptgt;
    endtask

    task automatic do_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt);
        set_upd(pc, tk, tgt, ptk, ptgt);
        step();
        upd_valid = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] pc);
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        step();
        fetch_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        fetch_valid = 1'b0;
        fetch_pc = 32'h0;
        upd_valid = 1'b0;
        upd_pc = 32'h0;
        upd_taken = 1'b0;
        upd_target = 32'h0;
        upd_pred_taken = 1'b0;
        upd_pred_target = 32'h0;
        step();
        step();
        chk("rst_pred_valid", 32'(pred_valid), 32'd0);
        chk("rst_pred_taken", 32'(pred_taken), 32'd0);
        chk("rst_pred_target", pred_target, 32'h0);
        chk("rst_mispredict", 32'(mispredict), 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'h0);
        rst = 1'b0;

        do_fetch(32'h100);
        chk("cold_pred_valid", 32'(pred_valid), 32'd1);
        chk("cold_pred_taken", 32'(pred_taken), 32'd0);
        chk("cold_pred_target", pred_target, 32'h104);
        step();
        chk("idle_pred_valid", 32'(pred_valid), 32'd0);
        chk("idle_target_hold", pred_target, 32'h104);

        do_upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
        chk("alloc_mispredict", 32'(mispredict), 32'd1);
        chk("alloc_redirect", redirect_pc, 32'h200);
        do_fetch(32'h100);
        chk("after_upd_mispredict", 32'(mispredict), 32'd0);
        chk("redirect_hold", redirect_pc, 32'h200);
        chk("wt_pred_taken", 32'(pred_taken), 32'd1);
        chk("wt_pred_target", pred_target, 32'h200);

        do_upd(32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
        chk("nt1_mispredict", 32'(mispredict), 32'd1);
        chk("nt1_redirect", redirect_pc, 32'h104);
        do_upd(32'h100, 1'b0, 32'h200, 1'b0, 32'h104);
        chk("nt2_mispredict", 32'(mispredict), 32'd0);
        chk("nt2_redirect_hold", redirect_pc, 32'h104);
        do_fetch(32'h100);
        chk("snt_pred_taken", 32'(pred_taken), 32'd0);
        chk("snt_pred_target", pred_target, 32'h104);

        do_upd(32'h100, 1'b0, 32'h200, 1'b0, 32'h104);
        do_upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
        do_fetch(32'h100);
        chk("sat_low_pred_taken", 32'(pred_taken), 32'd0);
        chk("sat_low_pred_target", pred_target, 32'h104);
        do_upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
        do_fetch(32'h100);
        chk("retrain_pred_taken", 32'(pred_taken), 32'd1);
        chk("retrain_pred_target", pred_target, 32'h200);

        do_upd(32'h140, 1'b1, 32'h500, 1'b0, 32'h144);
        do_fetch(32'h100);
        chk("alias_old_taken", 32'(pred_taken), 32'd0);
        chk("alias_old_target", pred_target, 32'h104);
        do_fetch(32'h140);
        chk("alias_new_taken", 32'(pred_taken), 32'd1);
        chk("alias_new_target", pred_target, 32'h500);

        fetch_valid = 1'b1;
        fetch_pc    = 32'h300;
        set_upd(32'h300, 1'b1, 32'h700, 1'b0, 32'h304);
        step();
        fetch_valid = 1'b0;
        upd_valid   = 1'b0;
        chk("rbw_pred_taken", 32'(pred_taken), 32'd0);
        chk("rbw_pred_target", pred_target, 32'h304);
        chk("rbw_mispredict", 32'(mispredict), 32'd1);
        chk("rbw_redirect", redirect_pc, 32'h700);
        do_fetch(32'h300);
        chk("rbw_next_taken", 32'(pred_taken), 32'd1);
        chk("rbw_next_target", pred_target, 32'h700);

        do_upd(32'h300, 1'b1, 32'h700, 1'b1, 32'h700);
        chk("correct_mispredict", 32'(mispredict), 32'd0);
        chk("correct_redirect_hold", redirect_pc, 32'h700);
        do_upd(32'h300, 1'b1, 32'h780, 1'b1, 32'h700);
        chk("tgt_mis_mispredict", 32'(mispredict), 32'd1);
        chk("tgt_mis_redirect", redirect_pc, 32'h780);
        do_fetch(32'h300);
        chk("tgt_retarget_taken", 32'(pred_taken), 32'd1);
        chk("tgt_retarget_target", pred_target, 32'h780);

        rst = 1'b1;
        fetch_valid = 1'b1;
        fetch_pc    = 32'h300;
        set_upd(32'h900, 1'b1, 32'hA00, 1'b0, 32'h904);
        step();
        rst = 1'b0;
        fetch_valid = 1'b0;
        upd_valid   = 1'b0;
        chk("rstupd_mispredict", 32'(mispredict), 32'd0);
        chk("rstupd_redirect", redirect_pc, 32'h0);
        chk("rstupd_pred_valid", 32'(pred_valid), 32'd0);
        step();
        chk("rstupd_no_pulse", 32'(mispredict), 32'd0);
        do_fetch(32'h900);
        chk("rstupd_no_alloc_taken", 32'(pred_taken), 32'd0);
        chk("rstupd_no_alloc_target", pred_target, 32'h904);
        do_fetch(32'h300);
        chk("rst_cleared_taken", 32'(pred_taken), 32'd0);
        chk("rst_cleared_target", pred_target, 32'h304);

        do_upd(32'h300, 1'b0, 32'h700, 1'b0, 32'h304);
        chk("nt_miss_mispredict", 32'(mispredict), 32'd0);
        do_fetch(32'h300);
        chk("nt_miss_no_alloc", 32'(pred_taken), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
